// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage RISC-V core.
//
// Every cycle it decides whether the PC and IF/ID advance, whether IF/ID or ID/EX
// get a NOP/bubble, and whether the back end of the pipe freezes. It handles
// load-use hazards, taken branches resolved in EX/MEM, and data-memory wait states.
// It also keeps free-running 32-bit stall and flush event counters.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   ifidRs1/ifidRs2        source register fields of the instruction in IF/ID
//   ifidUsesRs2            IF/ID instruction actually reads rs2
//   idexMemRead, idexRd    ID/EX holds a load writing idexRd
//   branchTaken            taken branch/jump resolved in EX/MEM this cycle
//   dmemBusy               data memory not ready, freeze everything
//   pcWrite, ifidWrite     load enables for PC and IF/ID
//   ifidFlush, idexBubble  NOP into IF/ID, bubble into ID/EX
//   pipeHold               freeze ID/EX, EX/MEM and MEM/WB
//   state                  0 = RUN, 1 = MEMWAIT, 2 = FLUSH
//   stallCount, flushCount performance event counters (wrap modulo 2^32)
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ifidRs1,
    input  logic [4:0]  ifidRs2,
    input  logic        ifidUsesRs2,
    input  logic        idexMemRead,
    input  logic [4:0]  idexRd,
    input  logic        branchTaken,
    input  logic        dmemBusy,
    output logic        pcWrite,
    output logic        ifidWrite,
    output logic        ifidFlush,
    output logic        idexBubble,
    output logic        pipeHold,
    output logic [1:0]  state,
    output logic [31:0] stallCount,
    output logic [31:0] flushCount
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StFlush   = 2'd2
    } state_e;

    localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES);
    localparam bit         NoFlush   = (FLUSH_CYCLES == 0);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic take_branch;
    logic stall_inc;
    logic flush_inc;

    assign load_use = idexMemRead && (idexRd != 5'd0) &&
                      ((idexRd == ifidRs1) || (ifidUsesRs2 && (idexRd == ifidRs2)));

    // A branch seen while memory was busy is replayed on the first free cycle.
    assign take_branch = branchTaken | pend_q;

    always_comb begin
        pcWrite    = 1'b1;
        ifidWrite  = 1'b1;
        ifidFlush  = 1'b0;
        idexBubble = 1'b0;
        pipeHold   = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;

        unique case (state_q)
            StRun, StMemWait: begin
                if (dmemBusy) begin
                    pcWrite   = 1'b0;
                    ifidWrite = 1'b0;
                    pipeHold  = 1'b1;
                    stall_inc = 1'b1;
                    state_d   = StMemWait;
                    if (branchTaken) begin
                        pend_d = 1'b1;
                    end
                end else begin
                    pend_d  = 1'b0;
                    state_d = StRun;
                    if (take_branch) begin
                        ifidFlush  = 1'b1;
                        idexBubble = 1'b1;
                        flush_inc  = 1'b1;
                        cnt_d      = FlushLoad;
                        state_d    = NoFlush ? StRun : StFlush;
                    end else if (load_use) begin
                        pcWrite    = 1'b0;
                        ifidWrite  = 1'b0;
                        idexBubble = 1'b1;
                        stall_inc  = 1'b1;
                    end
                end
            end
            StFlush: begin
                ifidFlush = 1'b1;
                if (dmemBusy) begin
                    // Freeze the flush window; the down-counter holds.
                    pcWrite   = 1'b0;
                    ifidWrite = 1'b0;
                    pipeHold  = 1'b1;
                    stall_inc = 1'b1;
                    if (branchTaken) begin
                        pend_d = 1'b1;
                    end
                end else begin
                    pend_d = 1'b0;
                    if (take_branch) begin
                        idexBubble = 1'b1;
                        flush_inc  = 1'b1;
                        cnt_d      = FlushLoad;
                    end else if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = 4'd0;
                pend_d  = 1'b0;
            end
        endcase

        stall_cnt_d = stall_inc ? stall_cnt_q + 32'd1 : stall_cnt_q;
        flush_cnt_d = flush_inc ? flush_cnt_q + 32'd1 : flush_cnt_q;

        // Hold the front end as a NOP source while in reset.
        if (reset) begin
            pcWrite    = 1'b0;
            ifidWrite  = 1'b0;
            ifidFlush  = 1'b1;
            idexBubble = 1'b1;
            pipeHold   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            cnt_q       <= 4'd0;
            pend_q      <= 1'b0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign state      = state_q;
    assign stallCount = stall_cnt_q;
    assign flushCount = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (FLUSH_CYCLES = 2): directed scenarios plus a
// randomized run, all against an event-level reference model.
module tb_hazard_ctrl;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ifidRs1, ifidRs2, idexRd;
    logic        ifidUsesRs2, idexMemRead, branchTaken, dmemBusy;
    logic        pcWrite, ifidWrite, ifidFlush, idexBubble, pipeHold;
    logic [1:0]  state;
    logic [31:0] stallCount, flushCount;

    hazard_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk         (clk),
        .reset       (reset),
        .ifidRs1     (ifidRs1),
        .ifidRs2     (ifidRs2),
        .ifidUsesRs2 (ifidUsesRs2),
        .idexMemRead (idexMemRead),
        .idexRd      (idexRd),
        .branchTaken (branchTaken),
        .dmemBusy    (dmemBusy),
        .pcWrite     (pcWrite),
        .ifidWrite   (ifidWrite),
        .ifidFlush   (ifidFlush),
        .idexBubble  (idexBubble),
        .pipeHold    (pipeHold),
        .state       (state),
        .stallCount  (stallCount),
        .flushCount  (flushCount)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: m_* describe the current cycle, n_* the cycle after.
    bit          m_pending = 0, n_pending = 0;
    int          m_left = 0, n_left = 0;  // flushed IF/ID cycles still owed
    logic [31:0] m_stall = 0, n_stall = 0;
    logic [31:0] m_flush = 0, n_flush = 0;
    int          m_state = 0, n_state = 0;
    bit          e_pc, e_ifw, e_fl, e_bub, e_hold;

    task automatic apply(input bit rst, input bit busy, input bit br, input bit mr,
                         input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input bit u2);
        bit lu;
        bit take;
        @(negedge clk);
        m_pending = n_pending;
        m_left    = n_left;
        m_stall   = n_stall;
        m_flush   = n_flush;
        m_state   = n_state;
        reset = rst; dmemBusy = busy; branchTaken = br; idexMemRead = mr;
        idexRd = rd; ifidRs1 = rs1; ifidRs2 = rs2; ifidUsesRs2 = u2;
        lu = mr && (rd != 0) && ((rd == rs1) || (u2 && (rd == rs2)));
        if (rst) begin
            {e_pc, e_ifw, e_fl, e_bub, e_hold} = 5'b00110;
            n_pending = 0; n_left = 0; n_stall = 0; n_flush = 0; n_state = 0;
        end else begin
            {e_pc, e_ifw, e_fl, e_bub, e_hold} = 5'b11000;
            n_pending = m_pending; n_left = m_left;
            n_stall = m_stall; n_flush = m_flush;
            if (busy) begin
                e_pc = 0; e_ifw = 0; e_hold = 1;
                e_fl = (m_left > 0);
                n_stall = m_stall + 1;
                if (br) n_pending = 1;
                n_state = (m_left > 0) ? 2 : 1;
            end else begin
                take = br || m_pending;
                n_pending = 0;
                if (take) begin
                    e_fl = 1; e_bub = 1;
                    n_flush = m_flush + 1;
                    n_left = FC;
                end else if (m_left > 0) begin
                    e_fl = 1;
                    n_left = m_left - 1;
                end else if (lu) begin
                    e_pc = 0; e_ifw = 0; e_bub = 1;
                    n_stall = m_stall + 1;
                end
                n_state = (n_left > 0) ? 2 : 0;
            end
        end
        #2;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
            n_vec++;
            if ({pcWrite, ifidWrite, ifidFlush, idexBubble, pipeHold} !== 5'b00110) begin
                n_err++;
                $display("FAIL reset_outputs: got %b want 00110",
                         {pcWrite, ifidWrite, ifidFlush, idexBubble, pipeHold});
            end
        end
        idle();
        n_vec++;
        if (state !== 2'd0 || stallCount !== 32'd0 || flushCount !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state: state=%0d stall=%0d flush=%0d want 0/0/0",
                     state, stallCount, flushCount);
        end
        n_vec++;
        if (pcWrite !== 1'b1 || ifidWrite !== 1'b1) begin
            n_err++;
            $display("FAIL reset_free: pcWrite=%b ifidWrite=%b want 1/1", pcWrite, ifidWrite);
        end
    endtask

    task automatic test_load_use();
        apply(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
        n_vec++;
        if ({pcWrite, ifidWrite, idexBubble} !== 3'b001) begin
            n_err++;
            $display("FAIL load_use_stall: pc/ifid/bub=%b want 001",
                     {pcWrite, ifidWrite, idexBubble});
        end
        idle();
        n_vec++;
        if (stallCount !== 32'd1 || pcWrite !== 1'b1) begin
            n_err++;
            $display("FAIL load_use_count: stall=%0d pc=%b want 1/1", stallCount, pcWrite);
        end
        apply(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
        n_vec++;
        if (pcWrite !== 1'b1 || idexBubble !== 1'b0) begin
            n_err++;
            $display("FAIL load_use_x0: pc=%b bub=%b want 1/0", pcWrite, idexBubble);
        end
        apply(0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0);
        n_vec++;
        if (pcWrite !== 1'b1 || idexBubble !== 1'b0) begin
            n_err++;
            $display("FAIL load_use_rs2_unused: pc=%b bub=%b want 1/0", pcWrite, idexBubble);
        end
        apply(0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 1);
        n_vec++;
        if (pcWrite !== 1'b0 || idexBubble !== 1'b1) begin
            n_err++;
            $display("FAIL load_use_rs2: pc=%b bub=%b want 0/1", pcWrite, idexBubble);
        end
        idle();
        n_vec++;
        if (stallCount !== 32'd2) begin
            n_err++;
            $display("FAIL load_use_total: stall=%0d want 2", stallCount);
        end
    endtask

    task automatic test_branch();
        logic [31:0] f0;
        f0 = m_flush;
        apply(0, 0, 1, 1, 5'd4, 5'd4, 5'd0, 0);
        n_vec++;
        if ({ifidFlush, idexBubble, pcWrite} !== 3'b111) begin
            n_err++;
            $display("FAIL branch_first: fl/bub/pc=%b want 111",
                     {ifidFlush, idexBubble, pcWrite});
        end
        for (int i = 0; i < FC; i++) begin
            apply(0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 0);
            n_vec++;
            if ({ifidFlush, idexBubble, pcWrite, state} !== 5'b10110) begin
                n_err++;
                $display("FAIL branch_flush%0d: fl/bub/pc/state=%b want 10110", i,
                         {ifidFlush, idexBubble, pcWrite, state});
            end
        end
        idle();
        n_vec++;
        if (ifidFlush !== 1'b0 || state !== 2'd0 || flushCount !== f0 + 32'd1) begin
            n_err++;
            $display("FAIL branch_done: fl=%b state=%0d flush=%0d want 0/0/%0d",
                     ifidFlush, state, flushCount, f0 + 32'd1);
        end
    endtask

    task automatic test_mem_wait();
        logic [31:0] s0, f0;
        s0 = m_stall;
        f0 = m_flush;
        for (int i = 1; i <= 4; i++) begin
            apply(0, 1, (i == 2), 0, 5'd0, 5'd0, 5'd0, 0);
            n_vec++;
            if ({pipeHold, pcWrite, ifidWrite, ifidFlush} !== 4'b1000) begin
                n_err++;
                $display("FAIL mem_wait_hold%0d: hold/pc/ifid/fl=%b want 1000", i,
                         {pipeHold, pcWrite, ifidWrite, ifidFlush});
            end
        end
        idle();
        n_vec++;
        if (stallCount !== s0 + 32'd4 || {ifidFlush, idexBubble, pipeHold} !== 3'b110) begin
            n_err++;
            $display("FAIL mem_wait_release: stall=%0d fl/bub/hold=%b want %0d/110",
                     stallCount, {ifidFlush, idexBubble, pipeHold}, s0 + 32'd4);
        end
        idle();
        n_vec++;
        if (flushCount !== f0 + 32'd1) begin
            n_err++;
            $display("FAIL mem_wait_flushcnt: flush=%0d want %0d", flushCount, f0 + 32'd1);
        end
        for (int i = 0; i < FC; i++) idle();
    endtask

    task automatic test_simultaneous();
        logic [31:0] s0;
        s0 = m_stall;
        apply(0, 1, 1, 1, 5'd9, 5'd9, 5'd0, 0);
        n_vec++;
        if ({pipeHold, pcWrite, idexBubble, ifidFlush} !== 4'b1000) begin
            n_err++;
            $display("FAIL simul_busy: hold/pc/bub/fl=%b want 1000",
                     {pipeHold, pcWrite, idexBubble, ifidFlush});
        end
        idle();
        n_vec++;
        if (state !== 2'd1 || stallCount !== s0 + 32'd1 ||
            {ifidFlush, idexBubble} !== 2'b11) begin
            n_err++;
            $display("FAIL simul_pending: state=%0d stall=%0d fl/bub=%b want 1/%0d/11",
                     state, stallCount, {ifidFlush, idexBubble}, s0 + 32'd1);
        end
        for (int i = 0; i < FC; i++) idle();
    endtask

    task automatic test_reset_mid_flush_and_wrap();
        apply(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        idle();
        apply(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        idle();
        n_vec++;
        if (state !== 2'd0 || ifidFlush !== 1'b0 || pcWrite !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_flush: state=%0d fl=%b pc=%b want 0/0/1",
                     state, ifidFlush, pcWrite);
        end
        @(posedge clk);
        #1;
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        n_stall = 32'hFFFF_FFFF;
        apply(0, 0, 0, 1, 5'd2, 5'd2, 5'd0, 0);
        n_vec++;
        if (stallCount !== 32'hFFFF_FFFF || pcWrite !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_preload: stall=%h pc=%b want ffffffff/0", stallCount, pcWrite);
        end
        idle();
        n_vec++;
        if (stallCount !== 32'd0) begin
            n_err++;
            $display("FAIL wrap: stall=%h want 00000000", stallCount);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            apply(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0), $urandom_range(0, 1),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 1));
            n_vec++;
            if ({pcWrite, ifidWrite, ifidFlush, idexBubble, pipeHold} !==
                {e_pc, e_ifw, e_fl, e_bub, e_hold}) begin
                n_err++;
                $display("FAIL rand_ctrl cyc %0d: got %b want %b", i,
                         {pcWrite, ifidWrite, ifidFlush, idexBubble, pipeHold},
                         {e_pc, e_ifw, e_fl, e_bub, e_hold});
            end
            n_vec++;
            if (state !== 2'(m_state) || stallCount !== m_stall || flushCount !== m_flush) begin
                n_err++;
                $display("FAIL rand_state cyc %0d: state=%0d stall=%0d flush=%0d want %0d/%0d/%0d",
                         i, state, stallCount, flushCount, m_state, m_stall, m_flush);
            end
        end
    endtask

    initial begin
        reset = 1'b1; dmemBusy = 1'b0; branchTaken = 1'b0; idexMemRead = 1'b0;
        idexRd = 5'd0; ifidRs1 = 5'd0; ifidRs2 = 5'd0; ifidUsesRs2 = 1'b0;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_simultaneous();
        test_reset_mid_flush_and_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
